// File: rtl/jk_bank_pkg.sv
// Shared types for the JK register bank: operating-mode encoding and its width.
// Imported by jk_cell and jk_reg_bank.
package jk_bank_pkg;

    localparam int JK_MODE_W = 2;

    typedef enum logic [JK_MODE_W-1:0] {
        JK_MODE_JK     = 2'b00,
        JK_MODE_LOAD   = 2'b01,
        JK_MODE_TOGGLE = 2'b10,
        JK_MODE_SHIFT  = 2'b11
    } jk_mode_t;

endpackage

// File: rtl/jk_cell.sv
// Combinational next-state for a single bit of the JK register bank.
// shift_in carries the bit's left-hand neighbour source (d[0] for bit 0, Q[i-1] otherwise).
module jk_cell
    import jk_bank_pkg::*;
(
    input  jk_mode_t mode,
    input  logic     j,
    input  logic     k,
    input  logic     d_bit,
    input  logic     shift_in,
    input  logic     q,
    output logic     q_next
);

    always_comb begin
        q_next = q;
        case (mode)
            JK_MODE_JK: begin
                case ({j, k})
                    2'b00:   q_next = q;
                    2'b01:   q_next = 1'b0;
                    2'b10:   q_next = 1'b1;
                    default: q_next = ~q;
                endcase
            end
            JK_MODE_LOAD:   q_next = d_bit;
            JK_MODE_TOGGLE: q_next = q ^ j;
            JK_MODE_SHIFT:  q_next = shift_in;
            default:        q_next = q;
        endcase
    end

endmodule

// File: rtl/jk_reg_bank.sv
// WIDTH-bit bank of JK flip-flops with JK / LOAD / TOGGLE / SHIFT modes and a change flag.
// Define JK_ACT_CNT_EN to add the saturating act_cnt activity counter port.
module jk_reg_bank
    import jk_bank_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [JK_MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]     J,
    input  logic [WIDTH-1:0]     K,
    input  logic [WIDTH-1:0]     d,
    output logic [WIDTH-1:0]     Q,
    output logic [WIDTH-1:0]     Qn,
    output logic                 changed
`ifdef JK_ACT_CNT_EN
    ,
    output logic [CNT_W-1:0]     act_cnt
`endif
);

    // No valid/ready handshake: mode/J/K/d are consumed on every edge where en=1.

    jk_mode_t         mode_e;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             will_change;

    assign mode_e = jk_mode_t'(mode);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic shift_in;
        if (i == 0) begin : g_first
            assign shift_in = d[0];
        end else begin : g_rest
            assign shift_in = q_reg[i-1];
        end

        jk_cell u_cell (
            .mode     (mode_e),
            .j        (J[i]),
            .k        (K[i]),
            .d_bit    (d[i]),
            .shift_in (shift_in),
            .q        (q_reg[i]),
            .q_next   (q_next[i])
        );
    end

    assign will_change = |(q_next ^ q_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_reg   <= RESET_VAL;
            changed <= 1'b0;
        end else if (en) begin
            q_reg   <= q_next;
            changed <= will_change;
        end else begin
            changed <= 1'b0;
        end
    end

    // Qn is derived, never stored, so it tracks Q even while reset is held.
    assign Q  = q_reg;
    assign Qn = ~q_reg;

`ifdef JK_ACT_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_cnt <= '0;
        end else if (en && will_change && (act_cnt != CNT_MAX)) begin
            act_cnt <= act_cnt + CNT_ONE;
        end
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule
